line_buffer_pixel_feeder: RTL
=============================

Name: line_buffer_pixel_feeder

Overview:
Write-side driver for the single-line FIFO buffer in the edge-detection datapath. On start_i it reads an IMG_WIDTH x IMG_HEIGHT 8-bit greyscale frame in raster order from a synchronous-read pixel memory. It pushes each row into the line buffer's write port (we/data) and waits for the buffer's line-done indication before starting the next row. It pulses frame_done_o after the last row is acknowledged.

Parameters:
IMG_WIDTH, 10, pixels per row (>=2)
IMG_HEIGHT, 8, rows per frame (>=1)
DATA_W, 8, pixel width
ADDR_W, 16, pixel memory address width; IMG_WIDTH*IMG_HEIGHT <= 2**ADDR_W
COL_W, 8, column counter width; IMG_WIDTH <= 2**COL_W
ROW_W, 8, row counter width; IMG_HEIGHT <= 2**ROW_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start_i  in  1  frame start request, sampled only in IDLE
mem_re_o  out  1  pixel memory read enable
mem_addr_o  out  ADDR_W  pixel memory address
mem_data_i  in  DATA_W  read data, valid one cycle after mem_re_o
we_o  out  1  line buffer write enable
data_o  out  DATA_W  line buffer write data
line_done_i  in  1  line buffer full/row-consumed indication
busy_o  out  1  high from the cycle after start acceptance until return to IDLE
row_o  out  ROW_W  index of the row currently being fed
frame_done_o  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: state=IDLE. mem_re_o, we_o, busy_o and frame_done_o are 0. mem_addr_o, data_o and row_o are 0. Column and address counters are 0. Reset asserted mid-frame aborts the frame: all outputs reach reset values at that edge, and no further writes occur.
- States are IDLE, ROW, WAIT_ACK and DONE.
- IDLE: on start_i=1, go to ROW with addr=0, col=0, row=0. start_i in any other state is ignored (not queued).
- ROW: mem_re_o=1 and mem_addr_o=addr every cycle. Each cycle addr and col increment. When col==IMG_WIDTH-1, col clears and the state goes to WAIT_ACK. addr is not reset per row. It runs continuously 0..IMG_WIDTH*IMG_HEIGHT-1 using increment only, with no multiplier.
- Write pipeline: we_o is mem_re_o delayed one register. data_o is registered from mem_data_i on the cycle we_o asserts. This gives exactly IMG_WIDTH consecutive we_o cycles per row, starting one cycle after the first mem_re_o. The last write of a row occurs in the first WAIT_ACK cycle.
- WAIT_ACK: mem_re_o=0. line_done_i is sampled only in this state and only after the final write of the row has been issued, so it is ignored in the first WAIT_ACK cycle.
  - On line_done_i=1 with row==IMG_HEIGHT-1, go to DONE.
  - On line_done_i=1 otherwise, row increments and the state goes to ROW.
  - The block waits indefinitely with no timeout.
- line_done_i asserted during IDLE, ROW or DONE has no effect and is not latched.
- DONE: frame_done_o=1 for exactly one cycle. The next state is IDLE. busy_o drops in the IDLE cycle.
- Cadence: no gap cycles inside a row. Between rows there is a minimum of 2 idle write cycles: the WAIT_ACK sample cycle plus the ROW re-entry latency.
- Counters never exceed their terminal values. No wrap-around of addr within a frame. addr returns to 0 only on a new start.

Test Plan:
1. Reset then start_i pulse, memory preloaded with mem[a]=a[7:0], line_done_i tied high after each row (IMG_WIDTH=10, IMG_HEIGHT=2) -> we_o high cycles 2..11 after start with data_o=0..9. Second row data_o=10..19. frame_done_o is a single pulse. Exactly 20 writes.
2. line_done_i held low for 5 cycles after row 0 -> no mem_re_o and no we_o during the stall. Row 1 reads begin 1 cycle after line_done_i is seen. row_o=1 during row 1.
3. start_i pulsed repeatedly while busy_o=1 -> ignored. Exactly one frame of 80 writes (default parameters). One frame_done_o.
4. line_done_i pulsed high mid-row (col=4) -> no effect. Block still waits in WAIT_ACK for a fresh line_done_i.
5. rst asserted at row 1 col 3 -> next cycle we_o=0, mem_re_o=0, busy_o=0, row_o=0. A subsequent start_i restarts at addr 0.
6. IMG_HEIGHT=1, back-to-back frames (start_i re-asserted in the IDLE cycle after frame_done_o) -> second frame accepted. Addresses restart at 0 and data_o=0..9 again.

Source files
------------

// File: rtl/line_buffer_pixel_feeder.sv
// Feeds a greyscale frame row by row from a synchronous-read pixel memory into a
// single-line buffer, holding off between rows until the buffer reports the line done.
module line_buffer_pixel_feeder #(
  parameter int IMG_WIDTH  = 10,
  parameter int IMG_HEIGHT = 8,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int COL_W      = 8,
  parameter int ROW_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              we_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              line_done_i,
  output logic              busy_o,
  output logic [ROW_W-1:0]  row_o,
  output logic              frame_done_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // ROW   | reading one row from pixel memory, one pixel per cycle
  // WAIT  | last write draining, then waiting for line_done_i
  // DONE  | one-cycle frame_done_o pulse
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ROW      = 2'd1;
  localparam logic [1:0] S_WAIT_ACK = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              we_q;
  logic [DATA_W-1:0] data_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ROW;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_ROW: begin
        // addr parks on the final pixel so it never passes its terminal value
        if (!(col_q == COL_LAST && row_q == ROW_LAST)) begin
          addr_d = addr_q + 1'b1;
        end
        if (col_q == COL_LAST) begin
          col_d   = '0;
          state_d = S_WAIT_ACK;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_WAIT_ACK: begin
        // we_q high means the row's final write is still on the bus this cycle
        if (line_done_i && !we_q) begin
          if (row_q == ROW_LAST) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_ROW;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      we_q    <= (state_q == S_ROW);
      if (we_q) begin
        data_q <= mem_data_i;
      end
    end
  end

  // Memory read data is already registered; pass it through while writing, hold otherwise.
  assign data_o       = we_q ? mem_data_i : data_q;
  assign we_o         = we_q;
  assign mem_re_o     = (state_q == S_ROW);
  assign mem_addr_o   = addr_q;
  assign busy_o       = (state_q != S_IDLE);
  assign row_o        = row_q;
  assign frame_done_o = (state_q == S_DONE);

endmodule
